// File: rtl/byte_assembler_if.sv
// rtl/byte_assembler_if.sv - request, RAM byte port and result signals of the byte assembler
interface byte_assembler_if;
    logic        start;
    logic        we;
    logic [2:0]  num;
    logic [31:0] wdata;
    logic [7:0]  byte_in;
    logic [7:0]  byte_out;
    logic        byte_we;
    logic        byte_re;
    logic        busy;
    logic        done;
    logic [31:0] rdata;

    modport master (
        output start, we, num, wdata, byte_in,
        input  byte_out, byte_we, byte_re, busy, done, rdata
    );

    modport slave (
        input  start, we, num, wdata, byte_in,
        output byte_out, byte_we, byte_re, busy, done, rdata
    );
endinterface

// File: rtl/byte_assembler.sv
// rtl/byte_assembler.sv - serializes word/half/byte stores and assembles extended loads over a byte RAM port
module byte_assembler (
    input  logic            clk,
    input  logic            rst,
    byte_assembler_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_XFER = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]  r_state;
    logic [1:0]  r_k;
    logic        r_we;
    logic [2:0]  r_num;
    logic [31:0] r_wdata;
    logic [31:0] r_asm;
    logic [31:0] r_rdata;

    logic [2:0]  w_num_norm;
    logic [1:0]  w_last;
    logic [31:0] w_full;
    logic [31:0] w_ext;
    logic        w_xfer;
    logic        w_byte_we;

    // Sizes 101-111 collapse to byte unsigned before being latched.
    always_comb w_num_norm = (bus.num > 3'd4) ? 3'd4 : bus.num;

    always_comb begin
        case (r_num)
            3'd0:       w_last = 2'd3;
            3'd1, 3'd2: w_last = 2'd1;
            default:    w_last = 2'd0;
        endcase
    end

    // The final lane arrives during WAIT, so the result is formed from the live byte.
    always_comb begin
        w_full                       = r_asm;
        w_full[{w_last, 3'b000} +: 8] = bus.byte_in;
    end

    always_comb begin
        case (r_num)
            3'd1:    w_ext = {{16{w_full[15]}}, w_full[15:0]};
            3'd2:    w_ext = {16'h0000, w_full[15:0]};
            3'd3:    w_ext = {{24{w_full[7]}}, w_full[7:0]};
            3'd4:    w_ext = {24'h000000, w_full[7:0]};
            default: w_ext = w_full;
        endcase
    end

    assign w_xfer       = (r_state == S_XFER);
    assign w_byte_we    = w_xfer && r_we;
    assign bus.byte_we  = w_byte_we;
    assign bus.byte_re  = w_xfer && !r_we;
    assign bus.byte_out = w_byte_we ? r_wdata[{r_k, 3'b000} +: 8] : 8'h00;
    assign bus.busy     = w_xfer || (r_state == S_WAIT);
    assign bus.done     = (r_state == S_DONE);
    assign bus.rdata    = r_rdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_k     <= 2'd0;
            r_we    <= 1'b0;
            r_num   <= 3'd0;
            r_wdata <= 32'h0;
            r_asm   <= 32'h0;
            r_rdata <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_we    <= bus.we;
                        r_num   <= w_num_norm;
                        r_wdata <= bus.wdata;
                        r_k     <= 2'd0;
                        r_asm   <= 32'h0;
                        r_state <= S_XFER;
                    end
                end
                S_XFER: begin
                    // Read data lags the strobe by one beat, so beat k captures lane k-1.
                    if (!r_we && (r_k != 2'd0))
                        r_asm[{r_k - 2'd1, 3'b000} +: 8] <= bus.byte_in;
                    if (r_k == w_last)
                        r_state <= r_we ? S_DONE : S_WAIT;
                    else
                        r_k <= r_k + 2'd1;
                end
                S_WAIT: begin
                    r_asm   <= w_full;
                    r_rdata <= w_ext;
                    r_state <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
